// File: rtl/modmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modmul_ctrl
// Purpose  : Job controller for a duplicated (primary + shadow) modular
//            multiplier. It accepts operand triples, drives them into the
//            fixed-latency datapath, and tracks each one with a valid/index
//            shift chain. Returned results go into a credit-protected result
//            FIFO, tagged with a primary/shadow mismatch flag. Fault status is
//            kept per job.
// Ports    : clk, rst_n                 clock, synchronous active-low reset
//            start, len, busy, done     job control
//            in_valid/in_ready, in_a/in_b/in_tw
//                                       operand stream
//            mm_a, mm_b, mm_tw          registered operands to the datapath
//            mm_e, mm_o, mm_o_fault     datapath returns (shadow = mm_o_fault)
//            out_valid/out_ready, out_e/out_o/out_idx/out_err
//                                       result stream
//            fault, fault_idx, fault_cnt
//                                       sticky fault status of current job
// Config   : MODMUL_CTRL_ABORT_ON_FAULT_EN -- when defined, the first mismatch
//            aborts the job through the FLUSH state.
// Revision : 1.0 - initial release
// ============================================================================
module modmul_ctrl #(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // job control
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  // operand input
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_tw,
  // datapath drive
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_tw,
  // datapath return
  input  logic [WIDTH-1:0] mm_e,
  input  logic [WIDTH-1:0] mm_o,
  input  logic [WIDTH-1:0] mm_o_fault,
  // result output
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_o,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_err,
  // fault status
  output logic             fault,
  output logic [CNT_W-1:0] fault_idx,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Occupancy (FIFO + in flight) can reach 2*FIFO_DEPTH in the sum.
  localparam int OCC_W = PTR_W + 2;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0] OCC_ONE   = {{(OCC_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
  localparam logic [1:0] ST_FLUSH = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, issued_q, retired_q;

  // operand register stage and its tracking companion
  logic [WIDTH-1:0] mm_a_q, mm_b_q, mm_tw_q;
  logic             mm_vld_q;
  logic [CNT_W-1:0] mm_idx_q;

  // tracking chain, aligned so the last stage coincides with mm_e/mm_o
  logic [LATENCY-1:0] chain_v_q;
  logic [CNT_W-1:0]   chain_idx_q [LATENCY];
  logic [OCC_W-1:0]   inflight_q;

  // result FIFO
  logic [WIDTH-1:0] fifo_e_q   [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_o_q   [FIFO_DEPTH];
  logic [CNT_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic             fifo_err_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] fifo_cnt_q;

  logic             fault_q;
  logic [CNT_W-1:0] fault_idx_q, fault_cnt_q;
  logic             zdone_q;

  logic             job_start, zero_start, accept, emerge, mismatch;
  logic             push, pop, flushing, abort_hit, fifo_empty, have_credit;
  logic             drain_done, flush_done;
  logic [CNT_W-1:0] emerge_idx;
  logic [OCC_W-1:0] occupancy;

  assign job_start  = (state_q == ST_IDLE) && start && (len != '0);
  assign zero_start = (state_q == ST_IDLE) && start && (len == '0);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign occupancy  = fifo_cnt_q + inflight_q;
  assign have_credit = (occupancy < OCC_DEPTH);
  assign accept     = in_valid && in_ready;
  assign emerge     = chain_v_q[LATENCY-1];
  assign emerge_idx = chain_idx_q[LATENCY-1];

`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
  assign flushing  = (state_q == ST_FLUSH);
`else
  assign flushing  = 1'b0;
`endif

  // Results that emerge while flushing are discarded unchecked.
  assign mismatch = emerge && !flushing && (mm_o != mm_o_fault);

`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
  assign abort_hit = mismatch;
`else
  assign abort_hit = 1'b0;
`endif

  // The faulting result itself is dropped when aborting.
  assign push       = emerge && !flushing && !abort_hit;
  assign pop        = out_valid && out_ready;
  assign drain_done = (retired_q == len_q) && fifo_empty;
  assign flush_done = (inflight_q == '0) && fifo_empty;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (job_start) state_d = ST_RUN;
      end
      ST_RUN: begin
`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
        if (abort_hit) state_d = ST_FLUSH;
        else
`endif
        if (issued_q == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
        if (abort_hit) state_d = ST_FLUSH;
        else
`endif
        if (drain_done) state_d = ST_IDLE;
      end
`ifdef MODMUL_CTRL_ABORT_ON_FAULT_EN
      ST_FLUSH: begin
        if (flush_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_RUN) && (issued_q < len_q) && have_credit;
    out_valid = !fifo_empty && !flushing;
    done      = zdone_q
              || ((state_q == ST_DRAIN) && drain_done)
              || (flushing && flush_done);
  end

  // --------------------------------------------------------------------------
  // Job counters, operand register, tracking chain valid bits
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_tw_q    <= '0;
      mm_vld_q   <= 1'b0;
      mm_idx_q   <= '0;
      chain_v_q  <= '0;
      inflight_q <= '0;
      zdone_q    <= 1'b0;
    end else begin
      zdone_q <= zero_start;

      if (job_start) begin
        len_q     <= len;
        issued_q  <= '0;
        retired_q <= '0;
      end else begin
        if (accept) issued_q  <= issued_q + CNT_ONE;
        if (emerge) retired_q <= retired_q + CNT_ONE;
      end

      // mm_* hold their last value between transfers; mm_vld_q qualifies.
      if (accept) begin
        mm_a_q   <= in_a;
        mm_b_q   <= in_b;
        mm_tw_q  <= in_tw;
        mm_idx_q <= issued_q;
      end
      mm_vld_q <= accept;

      chain_v_q[0] <= mm_vld_q;
      for (int k = 1; k < LATENCY; k++) begin
        chain_v_q[k] <= chain_v_q[k-1];
      end

      case ({accept, emerge})
        2'b10:   inflight_q <= inflight_q + OCC_ONE;
        2'b01:   inflight_q <= inflight_q - OCC_ONE;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Index payload travels alongside the valid bits; no reset needed.
  always_ff @(posedge clk) begin
    chain_idx_q[0] <= mm_idx_q;
    for (int k = 1; k < LATENCY; k++) begin
      chain_idx_q[k] <= chain_idx_q[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flushing) begin
      // Discard everything buffered; nothing is pushed while flushing.
      rd_ptr_q   <= wr_ptr_q;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + OCC_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - OCC_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_e_q[wr_ptr_q]   <= mm_e;
      fifo_o_q[wr_ptr_q]   <= mm_o;
      fifo_idx_q[wr_ptr_q] <= emerge_idx;
      fifo_err_q[wr_ptr_q] <= (mm_o != mm_o_fault);
    end
  end

  assign out_e   = fifo_e_q[rd_ptr_q];
  assign out_o   = fifo_o_q[rd_ptr_q];
  assign out_idx = fifo_idx_q[rd_ptr_q];
  assign out_err = out_valid && fifo_err_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Fault status: sticky flag, first index, saturating count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
      fault_cnt_q <= '0;
    end else if (job_start) begin
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
      fault_cnt_q <= '0;
    end else if (mismatch) begin
      if (!fault_q) begin
        fault_q     <= 1'b1;
        fault_idx_q <= emerge_idx;
      end
      if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + CNT_ONE;
    end
  end

  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign mm_tw     = mm_tw_q;
  assign fault     = fault_q;
  assign fault_idx = fault_idx_q;
  assign fault_cnt = fault_cnt_q;

endmodule
`default_nettype wire

// File: doc/modmul_ctrl.md
MODMUL_CTRL -- requirements
Module: modmul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 6, fixed datapath latency (multiply latency plus reduction latency), at least 1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, result buffer entries, a power of two, at least 2.
REQ-004 SHALL have parameter CNT_W, default 8, width of job length and indices.
REQ-005 SHALL have these clock and reset ports: clk, input, 1, clock; rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have these job control ports: start, input, 1, job start pulse; len, input, CNT_W, operation count; busy, output, 1, job active; done, output, 1, one-cycle job-complete pulse.
REQ-007 SHALL have these operand input ports: in_valid, input, 1; in_ready, output, 1; in_a, in_b, in_tw, input, WIDTH each.
REQ-008 SHALL have these datapath drive ports: mm_a, mm_b, mm_tw, output, WIDTH each, registered operands to the duplicated modular multiplier.
REQ-009 SHALL have these datapath return ports: mm_e, mm_o, mm_o_fault, input, WIDTH each, primary even, primary odd and shadow odd results.
REQ-010 SHALL have these result output ports: out_valid, output, 1; out_ready, input, 1; out_e, out_o, output, WIDTH each; out_idx, output, CNT_W; out_err, output, 1, per-result mismatch flag.
REQ-011 SHALL have these fault status ports: fault, output, 1, sticky; fault_idx, output, CNT_W, index of the first mismatch; fault_cnt, output, CNT_W, saturating mismatch count.

Function
REQ-012 SHALL implement the states IDLE, RUN, DRAIN and FLUSH.
REQ-013 SHALL, in IDLE, on start with len>0, latch len, clear the issue and retire counters, clear fault, fault_idx and fault_cnt, and enter RUN.
REQ-014 SHALL, in IDLE, on start with len==0, pulse done in the next cycle and remain in IDLE.
REQ-015 SHALL ignore start while busy is high.
REQ-016 SHALL drive busy high whenever the state is not IDLE.
REQ-017 SHALL set in_ready = (state==RUN) && (issued<len) && (credits>0), where credits = FIFO_DEPTH - fifo_count - inflight.
REQ-018 SHALL, on each accepted transfer (in_valid && in_ready), register the operands onto mm_*, increment the issue counter, and push a valid bit and index into a LATENCY-deep tracking shift chain.
REQ-019 SHALL, when a chain entry emerges, sample mm_e, mm_o and mm_o_fault, set err = (mm_o != mm_o_fault), and write {e, o, idx, err} into the FIFO; the credit scheme SHALL guarantee the FIFO never overflows.
REQ-020 SHALL, on the first err of a job, set fault and capture fault_idx; fault_cnt SHALL increment on every err and saturate at all-ones.
REQ-021 SHALL drive out_valid while the FIFO is non-empty, present its head entry, and pop on out_valid && out_ready.
REQ-022 SHALL, when the FIFO pops and the tracking chain retires an entry in the same cycle, update both correctly.
REQ-023 SHALL transition RUN to DRAIN when issued==len.
REQ-024 SHALL, in DRAIN, when retired==len and the FIFO is empty, pulse done and return to IDLE.
REQ-025 SHALL keep mm_* holding their last value when no transfer is accepted; the tracking valid bit is the sole qualifier.
REQ-026 SHALL make the minimum latency from an accepted operand to out_valid equal LATENCY+2 cycles: one operand register, LATENCY, and one FIFO write.

Reset
REQ-027 SHALL, while rst_n is low at a clk edge, force state to IDLE, clear every chain valid bit, empty the FIFO and clear all counters.
REQ-028 SHALL hold the following outputs at 0 during reset: busy, done, in_ready, out_valid, out_err, fault, fault_idx, fault_cnt, mm_a, mm_b and mm_tw.
REQ-029 SHALL, on reset mid-job, abandon the job, discard in-flight results, and produce no done pulse.

Configuration
REQ-030 SHALL, with MODMUL_CTRL_ABORT_ON_FAULT_EN defined, on the first err move RUN or DRAIN to FLUSH: in_ready low, the chain drains, emerging results are discarded, the FIFO is emptied, then done pulses and the state returns to IDLE with fault high.
REQ-031 SHALL, with MODMUL_CTRL_ABORT_ON_FAULT_EN undefined, omit the FLUSH state; the job runs to completion, and every result is delivered with out_err marking each mismatch.

Verification
REQ-032 SHALL cover: LATENCY=6, len=4, matching returns, out_ready=1 -> out_idx 0..3 in order, out_err=0, first out_valid 8 cycles after the first accept, done 1 cycle after the last pop.
REQ-033 SHALL cover: FIFO_DEPTH=8, out_ready=0, len=20 -> in_ready drops after 8 accepts, no overflow; releasing out_ready completes all 20 results.
REQ-034 SHALL cover: mm_o_fault differs on idx 2 and idx 5, abort macro undefined -> fault=1, fault_idx=2, fault_cnt=2, out_err high on exactly those two results.
REQ-035 SHALL cover: the same stimulus with the abort macro defined -> no result after idx 1 is delivered, done pulses, fault=1, fault_idx=2.
REQ-036 SHALL cover: start with len=0 -> done 1 cycle later and busy stays 0; start asserted during a job -> ignored.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-job with 3 operations in flight -> all outputs 0, out_valid never asserts for the old job, and a new job runs cleanly.
